// File: rtl/mod_inverse_pkg.sv
// Shared definitions for the modular-inverse unit.
//   W_DEF  : default operand width
//   SW_DEF : signed width of the Bezout coefficient registers (W + 2)
//   state_t: controller states
package mod_inverse_pkg;
    localparam int W_DEF  = 4;
    localparam int SW_DEF = W_DEF + 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ITER  = 2'd1,
        S_FINAL = 2'd2
    } state_t;
endpackage

// File: rtl/mod_inverse_divmod.sv
// Combinational unsigned W-bit divide.
//   i_num, i_den : dividend, divisor
//   o_quo, o_rem : quotient, remainder (i_den == 0 gives quo 0, rem i_num)
module mod_inverse_divmod #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_num,
    input  logic [W-1:0] i_den,
    output logic [W-1:0] o_quo,
    output logic [W-1:0] o_rem
);
    always_comb begin
        o_quo = '0;
        o_rem = i_num;
        if (i_den != '0) begin
            o_quo = i_num / i_den;
            o_rem = i_num % i_den;
        end
    end
endmodule

// File: rtl/mod_inverse.sv
// Sequential modular inverse via extended Euclid, one quotient step per cycle.
//   clk, rst_n : clock, async active-low reset
//   start      : request, sampled in IDLE; a, m latched on acceptance
//   busy       : high from accepting edge until the edge raising done
//   done       : one-cycle result strobe
//   ok, inv    : inverse exists / inverse in [1, m-1] (0 when !ok); held until next done
module mod_inverse
    import mod_inverse_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] m,
    output logic         busy,
    output logic         done,
    output logic         ok,
    output logic [W-1:0] inv
);
    localparam int SW = W + 2;

    state_t               r_state;
    logic [W-1:0]         r_r_old, r_r, r_m;
    logic signed [SW-1:0] r_t_old, r_t;
    logic                 r_deg;

    logic [W-1:0]         w_num, w_den, w_q, w_rem;
    logic signed [SW-1:0] w_t_new;
    logic [W-1:0]         w_inv;

    // One divider serves both the a mod m reduction at load and the
    // per-step quotient/remainder while iterating.
    assign w_num = (r_state == S_IDLE) ? a : r_r_old;
    assign w_den = (r_state == S_IDLE) ? m : r_r;

    mod_inverse_divmod #(.W(W)) u_divmod (
        .i_num (w_num),
        .i_den (w_den),
        .o_quo (w_q),
        .o_rem (w_rem)
    );

    // q*t formed at 2W+2 bits, kept at W+2; |t| <= m so nothing is lost.
    assign w_t_new = r_t_old - SW'($signed({{(W+2){1'b0}}, w_q}) *
                                   $signed({{W{r_t[SW-1]}}, r_t}));

    // Fold a negative coefficient into [0, m-1].
    assign w_inv = r_t_old[SW-1] ? W'(r_t_old + $signed({2'b00, r_m}))
                                 : r_t_old[W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_r_old <= '0;
            r_r     <= '0;
            r_m     <= '0;
            r_t_old <= '0;
            r_t     <= '0;
            r_deg   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ok      <= 1'b0;
            inv     <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        r_m     <= m;
                        r_t_old <= '0;
                        r_state <= S_ITER;
                        if (m < W'(2)) begin
                            // No inverse modulo 0 or 1. Passing through ITER
                            // with r = 0 gives the same two-cycle latency as
                            // a zero-step run.
                            r_deg   <= 1'b1;
                            r_r_old <= '0;
                            r_r     <= '0;
                            r_t     <= '0;
                        end else begin
                            r_deg   <= 1'b0;
                            r_r_old <= m;
                            r_r     <= w_rem;
                            r_t     <= SW'(1);
                        end
                    end
                end
                S_ITER: begin
                    if (r_r != '0) begin
                        r_r_old <= r_r;
                        r_r     <= w_rem;
                        r_t_old <= r_t;
                        r_t     <= w_t_new;
                    end else begin
                        r_state <= S_FINAL;
                    end
                end
                S_FINAL: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                    if (!r_deg && r_r_old == W'(1)) begin
                        ok  <= 1'b1;
                        inv <= w_inv;
                    end else begin
                        ok  <= 1'b0;
                        inv <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mod_inverse.sv
module tb_mod_inverse;
    logic       clk, rst_n, start;
    logic [3:0] a, m;
    logic       busy, done, ok;
    logic [3:0] inv;

    mod_inverse #(.W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .m     (m),
        .busy  (busy),
        .done  (done),
        .ok    (ok),
        .inv   (inv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       ok;
        logic [3:0] inv;
        int         due;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse.
    logic       prev_done, prev_ok;
    logic [3:0] prev_inv;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_done = 1'b0;
            prev_ok   = 1'b0;
            prev_inv  = 4'd0;
        end else begin
            if (done) begin
                chk("done_one_cycle", int'(prev_done), 0);
                chk("busy_low_at_done", int'(busy), 0);
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("ok", int'(ok), int'(e.ok));
                    chk("inv", int'(inv), int'(e.inv));
                    chk("latency", cyc, e.due);
                end
            end else begin
                chk("ok_held", int'(ok), int'(prev_ok));
                chk("inv_held", int'(inv), int'(prev_inv));
            end
            prev_done = done;
            prev_ok   = ok;
            prev_inv  = inv;
        end
    end

    // Reference: brute-force inverse search and Euclid step count.
    function automatic int ref_steps(input int av, input int mv);
        int ro, r, t, k;
        if (mv < 2) return 0;
        ro = mv; r = av % mv; k = 0;
        while (r != 0) begin
            t = ro % r; ro = r; r = t; k++;
        end
        return k;
    endfunction

    function automatic int ref_inv(input int av, input int mv);
        if (mv < 2) return 0;
        for (int x = 1; x < mv; x++)
            if ((av * x) % mv == 1) return x;
        return 0;
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("wait_bound", int'(busy), 0);
    endtask

    task automatic push(input logic eok, input int einv, input int k);
        exp_t e;
        e.ok  = eok;
        e.inv = 4'(einv);
        e.due = cyc + k + 2;
        sb.push_back(e);
    endtask

    task automatic send(input int av, input int mv, input logic eok, input int einv, input int k);
        @(negedge clk);
        a = 4'(av); m = 4'(mv); start = 1'b1;
        @(posedge clk); #1;
        push(eok, einv, k);
        chk("busy_after_accept", int'(busy), 1);
        start = 1'b0;
        wait_idle();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = 4'd0; m = 4'd0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ok", int'(ok), 0);
        chk("rst_inv", int'(inv), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors: a, m, ok, inv, steps
        send(3, 7, 1'b1, 5, 2);
        send(4, 8, 1'b0, 0, 1);
        send(10, 7, 1'b1, 5, 2);
        send(5, 1, 1'b0, 0, 0);
        send(0, 5, 1'b0, 0, 0);
        send(7, 15, 1'b1, 13, 2);

        // start re-pulsed while busy with other operands is ignored
        @(negedge clk);
        a = 4'd3; m = 4'd7; start = 1'b1;
        @(posedge clk); #1;
        push(1'b1, 5, 2);
        start = 1'b0;
        @(negedge clk);
        a = 4'd4; m = 4'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // start held across done: second run accepted back-to-back
        @(negedge clk);
        a = 4'd3; m = 4'd7; start = 1'b1;
        @(posedge clk); #1;
        push(1'b1, 5, 2);
        a = 4'd4; m = 4'd8;
        begin
            int n = 0;
            while (!done && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("b2b_done_seen", int'(done), 1);
        end
        @(posedge clk); #1;
        push(1'b0, 0, 1);
        chk("b2b_busy", int'(busy), 1);
        start = 1'b0;
        wait_idle();

        // ok = 1, inv = 13 held; reset mid-ITER must clear everything at once
        send(7, 15, 1'b1, 13, 2);
        @(negedge clk);
        a = 4'd3; m = 4'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_ok", int'(ok), 0);
        chk("abort_inv", int'(inv), 0);
        @(negedge clk); #2;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        send(1, 15, 1'b1, 1, 1);

        // Exhaustive sweep against the reference
        for (int mv = 0; mv < 16; mv++)
            for (int av = 0; av < 16; av++) begin
                int x;
                x = ref_inv(av, mv);
                send(av, mv, x != 0, x, ref_steps(av, mv));
            end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
